// File: rtl/sound_scheduler.sv
// Sound request arbiter: latches event pulses and plays the highest-priority one for its duration.
// Latency: a request is latched at the first edge, granted at the next edge when IDLE (or on preemption).
// Backpressure: none; requests are stored as pending bits until served, and a retrigger extends the active sound.
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset; clears state, counters and all pending requests
//   tick     duration time-base strobe, one clk wide; duration and gap counters move only on tick
//   req      request lines, a high level sets the matching pending bit (index NUM_REQ-1 wins)
//   tone     tone code of the playing source, 0 when silent
//   sound_on high while a sound is playing
//   grant    one-hot index of the playing source, 0 when silent
//   busy     high in PLAY or GAP, or while any request is pending

module sound_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 16,
  parameter logic [3:0]  TONE0     = 4'd1,
  parameter logic [3:0]  TONE1     = 4'd2,
  parameter logic [3:0]  TONE2     = 4'd3,
  parameter logic [3:0]  TONE3     = 4'd4,
  parameter int unsigned DUR0      = 10,
  parameter int unsigned DUR1      = 20,
  parameter int unsigned DUR2      = 30,
  parameter int unsigned DUR3      = 50,
  parameter int unsigned GAP_TICKS = 2,
  parameter bit          PREEMPT   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_REQ-1:0] req,
  output logic [3:0]         tone,
  output logic               sound_on,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] pending, pending_n;
  logic [CNT_W-1:0]   dur_cnt, dur_n;
  logic [CNT_W-1:0]   gap_cnt, gap_n;
  logic [IDX_W-1:0]   cur, cur_n;

  logic [IDX_W-1:0]   win;
  logic               any_pend;
  logic [NUM_REQ-1:0] cur_mask;
  logic               preempt_hit;

  // Per-source duration; a configured 0 still plays for one tick.
  function automatic logic [CNT_W-1:0] dur_of(input logic [IDX_W-1:0] idx);
    int unsigned d;
    case (int'(idx))
      0:       d = DUR0;
      1:       d = DUR1;
      2:       d = DUR2;
      3:       d = DUR3;
      default: d = 1;
    endcase
    return (d == 0) ? CNT_W'(1) : CNT_W'(d);
  endfunction

  function automatic logic [3:0] tone_of(input logic [IDX_W-1:0] idx);
    logic [3:0] t;
    case (int'(idx))
      0:       t = TONE0;
      1:       t = TONE1;
      2:       t = TONE2;
      3:       t = TONE3;
      default: t = 4'd0;
    endcase
    return t;
  endfunction

  // Fixed priority: the loop runs upward so the highest set index is the last write.
  always_comb begin
    win      = '0;
    any_pend = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending[i]) begin
        win      = IDX_W'(i);
        any_pend = 1'b1;
      end
    end
  end

  // Only valid while playing; used to keep a retrigger of the active source from queueing a replay.
  assign cur_mask    = (state == PLAY) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cur) : '0;
  assign preempt_hit = PREEMPT && (state == PLAY) && any_pend && (win > cur);

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    dur_n     = dur_cnt;
    gap_n     = gap_cnt;
    pending_n = pending | (req & ~cur_mask);

    case (state)
      IDLE: begin
        if (any_pend) begin
          state_n        = PLAY;
          cur_n          = win;
          dur_n          = dur_of(win);
          // Clearing after the OR also absorbs req[win] raised in this same cycle.
          pending_n[win] = 1'b0;
        end
      end

      PLAY: begin
        if (preempt_hit) begin
          // Aborted sound is simply dropped; no gap before the new one.
          cur_n          = win;
          dur_n          = dur_of(win);
          pending_n[win] = 1'b0;
        end else if (req[cur]) begin
          dur_n = dur_of(cur);
        end else if (tick) begin
          if (dur_cnt > CNT_W'(1)) begin
            dur_n = dur_cnt - CNT_W'(1);
          end else begin
            dur_n = '0;
            if (GAP_TICKS > 0) begin
              state_n = GAP;
              gap_n   = CNT_W'(GAP_TICKS);
            end else begin
              state_n = IDLE;
            end
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (gap_cnt > CNT_W'(1)) begin
            gap_n = gap_cnt - CNT_W'(1);
          end else begin
            gap_n   = '0;
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      dur_cnt <= '0;
      gap_cnt <= '0;
      cur     <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      dur_cnt <= dur_n;
      gap_cnt <= gap_n;
      cur     <= cur_n;
    end
  end

  // Outputs decode registered state only, so req and tick never reach them combinationally.
  assign sound_on = (state == PLAY);
  assign tone     = (state == PLAY) ? tone_of(cur) : 4'd0;
  assign grant    = (state == PLAY) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cur) : '0;
  assign busy     = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: one preempting instance and one non-preempting instance
// share the same stimulus. Expected outputs are packed as {sound_on, tone, grant, busy}.
module tb_sound_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] req;

  logic [3:0] tone_p, tone_n;
  logic       on_p, on_n;
  logic [3:0] grant_p, grant_n;
  logic       busy_p, busy_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sound_scheduler #(.PREEMPT(1'b1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .tone(tone_p), .sound_on(on_p), .grant(grant_p), .busy(busy_p)
  );

  sound_scheduler #(.PREEMPT(1'b0)) dut_np (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .tone(tone_n), .sound_on(on_n), .grant(grant_n), .busy(busy_n)
  );

  function automatic logic [9:0] play(input logic [3:0] t, input logic [3:0] g);
    return {1'b1, t, g, 1'b1};
  endfunction

  function automatic logic [9:0] quiet(input logic b);
    return {1'b0, 4'd0, 4'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {on,tone,grant,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input logic [9:0] exp);
    chk({tag, "_p"}, {on_p, tone_p, grant_p, busy_p}, exp);
  endtask

  task automatic chk_n(input string tag, input logic [9:0] exp);
    chk({tag, "_np"}, {on_n, tone_n, grant_n, busy_n}, exp);
  endtask

  task automatic chk_both(input string tag, input logic [9:0] exp);
    chk_p(tag, exp);
    chk_n(tag, exp);
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b1;
    req   = 4'b0000;

    // Reset state
    step();
    step();
    chk_both("reset", quiet(1'b0));
    reset = 1'b0;
    step();
    chk_both("post_reset_idle", quiet(1'b0));

    // Single request on source 0: latch edge, then 10 playing cycles, 2 gap cycles, idle
    req = 4'b0001;
    step();
    chk_both("s1_latched", quiet(1'b1));
    req = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_both($sformatf("s1_play%0d", k), play(4'd1, 4'b0001));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      chk_both($sformatf("s1_gap%0d", k), quiet(1'b1));
    end
    step();
    chk_both("s1_idle", quiet(1'b0));

    // Simultaneous requests 2 and 0: source 2 first, then source 0 after gap + one idle clk
    req = 4'b0101;
    step();
    chk_both("s2_latched", quiet(1'b1));
    req = 4'b0000;
    for (int k = 0; k < 30; k++) begin
      step();
      chk_both($sformatf("s2_play2_%0d", k), play(4'd3, 4'b0100));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk_both($sformatf("s2_gap_idle%0d", k), quiet(1'b1));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk_both($sformatf("s2_play0_%0d", k), play(4'd1, 4'b0001));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      chk_both($sformatf("s2_gap%0d", k), quiet(1'b1));
    end
    step();
    chk_both("s2_idle", quiet(1'b0));

    // Source 1 plays; req[3] arrives 5 ticks in. Sample G is the grant edge.
    req = 4'b0010;
    step();
    chk_both("s3_latched", quiet(1'b1));
    req = 4'b0000;
    for (int j = 0; j <= 5; j++) begin
      step();
      chk_both($sformatf("s3_play1_%0d", j), play(4'd2, 4'b0010));
    end
    req = 4'b1000;
    step();
    chk_both("s3_req3_latched", play(4'd2, 4'b0010));
    req = 4'b0000;
    for (int j = 7; j <= 75; j++) begin
      step();
      // Preempting instance: source 3 at G+7 for 50 clks, gap, then silence for good
      if (j <= 56)      chk_p($sformatf("s3_t%0d", j), play(4'd4, 4'b1000));
      else if (j <= 58) chk_p($sformatf("s3_t%0d", j), quiet(1'b1));
      else              chk_p($sformatf("s3_t%0d", j), quiet(1'b0));
      // Non-preempting instance: source 1 finishes 20 ticks, gap, idle clk, then source 3
      if (j <= 19)      chk_n($sformatf("s3_t%0d", j), play(4'd2, 4'b0010));
      else if (j <= 22) chk_n($sformatf("s3_t%0d", j), quiet(1'b1));
      else if (j <= 72) chk_n($sformatf("s3_t%0d", j), play(4'd4, 4'b1000));
      else if (j <= 74) chk_n($sformatf("s3_t%0d", j), quiet(1'b1));
      else              chk_n($sformatf("s3_t%0d", j), quiet(1'b0));
    end

    // Retrigger source 0 with 3 ticks left: reload to 10, continuous sound, no replay
    req = 4'b0001;
    step();
    chk_both("s5_latched", quiet(1'b1));
    req = 4'b0000;
    for (int j = 0; j <= 7; j++) begin
      step();
      chk_both($sformatf("s5_t%0d", j), play(4'd1, 4'b0001));
    end
    req = 4'b0001;
    for (int j = 8; j <= 22; j++) begin
      step();
      req = 4'b0000;
      if (j <= 17)      chk_both($sformatf("s5_t%0d", j), play(4'd1, 4'b0001));
      else if (j <= 19) chk_both($sformatf("s5_t%0d", j), quiet(1'b1));
      else              chk_both($sformatf("s5_t%0d", j), quiet(1'b0));
    end

    // Slow tick, source 3 playing with source 2 pending, then reset mid-sound
    tick = 1'b0;
    req  = 4'b1000;
    step();
    chk_both("s6_latched", quiet(1'b1));
    req = 4'b0000;
    step();
    chk_both("s6_play", play(4'd4, 4'b1000));
    for (int k = 0; k < 8; k++) begin
      tick = (k % 4 == 0);
      step();
      chk_both($sformatf("s6_slow%0d", k), play(4'd4, 4'b1000));
    end
    tick = 1'b0;
    req  = 4'b0100;
    step();
    chk_both("s6_pend2_no_preempt", play(4'd4, 4'b1000));
    req   = 4'b0000;
    reset = 1'b1;
    step();
    chk_both("s6_reset", quiet(1'b0));
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick = (k % 4 == 0);
      step();
      chk_both($sformatf("s6_after_reset%0d", k), quiet(1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Arbitrates sound requests from the game-event logic (wall hit, paddle hit, brick hit, game over) onto the single sound-duration/tone datapath.
- Latches request pulses, grants the highest-priority pending one, and drives the tone code and sound-enable for a per-source duration.
- Inserts a silent gap between consecutive sounds.
- Sits between the collision/game-state logic and the tone generator / audio codec driver.

Parameters:
- NUM_REQ, 4, number of requesters; index NUM_REQ-1 has highest priority.
- CNT_W, 16, width of the duration and gap counters.
- TONE0..TONE3, 1/2/3/4, 4-bit tone code for each requester.
- DUR0..DUR3, 10/20/30/50, sound duration in tick periods; a value of 0 is treated as 1.
- GAP_TICKS, 2, silent tick periods between sounds; 0 means no gap.
- PREEMPT, 1, 1 = a higher-priority pending request aborts the current sound.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- tick  in  1  duration time-base enable, one clk wide (e.g. 1 ms strobe); counters move only when tick=1.
- req  in  NUM_REQ  request lines, sampled every clk; a high level sets that source's pending bit.
- tone  out  4  tone code of the sound currently playing; 0 when silent.
- sound_on  out  1  high while a sound is playing.
- grant  out  NUM_REQ  one-hot index of the playing source; 0 when silent.
- busy  out  1  high in PLAY or GAP, or when any pending bit is set.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; pending=0, dur_cnt=0, gap_cnt=0, cur=0.
  - Outputs: tone=0, sound_on=0, grant=0, busy=0.
  - A reset asserted mid-sound silences the output at the next edge and discards all pending requests.
- Pending latch:
  - pending[i] is set at the edge where req[i]=1.
  - pending[i] is cleared at the edge where source i is granted.
  - req[i] high in the same cycle as its own grant is absorbed and not re-latched.
  - In PLAY, req[cur] reloads dur_cnt with DUR[cur] (retrigger/extend) and does not set pending[cur].
- Selection: fixed priority, highest set pending index wins.
- IDLE: if any pending bit is set, at the next edge:
  - state=PLAY, cur=winner, dur_cnt=DUR[winner], pending[winner]=0.
  - Grant is not gated by tick.
- PLAY:
  - sound_on=1, tone=TONE[cur], grant=onehot(cur).
  - On tick: if dur_cnt>1, decrement; if dur_cnt==1, end the sound.
  - End of sound: if GAP_TICKS>0, state=GAP with gap_cnt=GAP_TICKS; otherwise state=IDLE.
  - Result: sound_on stays high for exactly DUR ticks, counting the first tick after the grant edge.
- Preemption (PREEMPT=1, state PLAY): when a pending index is greater than cur, at the next edge:
  - Switch directly to the new source: cur, dur_cnt and tone reload, and its pending bit clears.
  - No gap is inserted; the aborted sound is dropped and not re-queued.
  - Preemption has priority over the tick/end-of-sound decision in the same cycle.
  - With PREEMPT=0, pending requests wait for IDLE.
- GAP:
  - Outputs silent (sound_on=0, tone=0, grant=0).
  - On tick: decrement gap_cnt; when gap_cnt==1, state=IDLE.
  - Requests keep latching; preemption does not apply.
  - From IDLE, the next grant occurs one clk later.
- Simultaneous requests in IDLE: highest index is granted; the others stay pending and are served in descending index order.
- tick held low: state and counters freeze in PLAY/GAP; requests still latch.
- busy = (state!=IDLE) or (pending!=0).
- All outputs are registered or decoded from registered state only; no combinational path from req or tick to any output.

Test Plan:
- Reset, tick=1 every cycle, pulse req=0001 for one cycle -> next edge sound_on=1, tone=1, grant=0001; sound_on stays 1 for 10 cycles, then 0 for 2 gap cycles; busy returns to 0.
- req=0101 in the same cycle -> source 2 plays first (tone=3, 30 cycles); after the gap plus 1 clk, source 0 plays (tone=1, 10 cycles).
- Source 1 playing, 5 ticks in; pulse req[3] -> next edge tone=4, grant=1000, sound lasts 50 cycles with no gap; source 1 does not replay.
- Same as above with PREEMPT=0 -> source 1 completes its 20 ticks, gap, then source 3 plays.
- Source 0 playing with 3 ticks left; pulse req[0] -> dur_cnt reloads to 10, sound_on stays continuously high, no second sound follows.
- tick strobe every 4th clk, reset asserted during PLAY with pending=0100 -> next edge all outputs 0 and busy=0; no sound after reset deasserts.
